// File: rtl/border_mask_2d.sv
// Border masking stage for a KSZ x KSZ 2D filter: tracks pixel/line position in the frame
// and replaces pixels within R = KSZ>>1 of any image edge with BORDER_VAL.
module border_mask_2d #(
  parameter int unsigned    DW         = 14,
  parameter int unsigned    KSZ        = 3,
  parameter int unsigned    IH         = 512,
  parameter int unsigned    IW         = 640,
  parameter logic [DW-1:0]  BORDER_VAL = '0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          din_valid,
  input  logic [DW-1:0] din,
  input  logic          vsync,
  output logic [DW-1:0] dout,
  output logic          dout_valid,
  output logic          vsync_out,
  output logic          border,
  output logic          line_end,
  output logic          frame_end,
  output logic          err_ovf
);

  localparam int unsigned R = KSZ >> 1;

  localparam logic [15:0] PxLo   = 16'(R);
  localparam logic [15:0] PxHi   = 16'(IW - R);
  localparam logic [15:0] PxLast = 16'(IW - 1);
  localparam logic [10:0] LnLo   = 11'(R);
  localparam logic [10:0] LnHi   = 11'(IH - R);
  localparam logic [10:0] LnLast = 11'(IH - 1);

  typedef enum logic [1:0] {StIdle, StActive, StDone} state_e;

  state_e        state_q, state_d;
  logic [15:0]   px_q, px_d;
  logic [10:0]   ln_q, ln_d;
  logic          err_q, err_d;

  logic [DW-1:0] dout_q;
  logic          dout_valid_q, vsync_out_q, border_q, line_end_q, frame_end_q;

  logic          accept, px_last, ln_last, is_border;

  always_comb begin
    accept    = din_valid && !vsync && (state_q != StDone);
    px_last   = (px_q == PxLast);
    ln_last   = (ln_q == LnLast);
    // Evaluated on the position of the pixel being accepted this cycle.
    is_border = (px_q < PxLo) || (px_q >= PxHi) || (ln_q < LnLo) || (ln_q >= LnHi);
  end

  always_comb begin
    state_d = state_q;
    px_d    = px_q;
    ln_d    = ln_q;
    err_d   = err_q;
    if (vsync) begin
      state_d = StIdle;
      px_d    = '0;
      ln_d    = '0;
      err_d   = 1'b0;
    end else if (accept) begin
      state_d = StActive;
      if (px_last) begin
        px_d = '0;
        if (ln_last) begin
          // Hold the line counter at the last line; the frame is complete.
          state_d = StDone;
        end else begin
          ln_d = ln_q + 11'd1;
        end
      end else begin
        px_d = px_q + 16'd1;
      end
    end else if (state_q == StDone && din_valid) begin
      err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      px_q    <= '0;
      ln_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      px_q    <= px_d;
      ln_q    <= ln_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      vsync_out_q  <= 1'b0;
      border_q     <= 1'b0;
      line_end_q   <= 1'b0;
      frame_end_q  <= 1'b0;
    end else begin
      dout_valid_q <= accept;
      vsync_out_q  <= vsync;
      border_q     <= accept && is_border;
      line_end_q   <= accept && px_last;
      frame_end_q  <= accept && px_last && ln_last;
      if (accept) begin
        dout_q <= is_border ? BORDER_VAL : din;
      end
    end
  end

  assign dout       = dout_q;
  assign dout_valid = dout_valid_q;
  assign vsync_out  = vsync_out_q;
  assign border     = border_q;
  assign line_end   = line_end_q;
  assign frame_end  = frame_end_q;
  assign err_ovf    = err_q;

endmodule

// File: tb/tb_border_mask_2d.sv
// Scoreboard bench for border_mask_2d on an 8x6 image with a 3x3 kernel.
module tb_border_mask_2d;

  localparam int unsigned DW = 14;
  localparam int unsigned IW = 8;
  localparam int unsigned IH = 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          din_valid = 1'b0;
  logic [DW-1:0] din = '0;
  logic          vsync = 1'b0;
  logic [DW-1:0] dout;
  logic          dout_valid, vsync_out, border, line_end, frame_end, err_ovf;

  border_mask_2d #(
    .DW         (DW),
    .KSZ        (3),
    .IH         (IH),
    .IW         (IW),
    .BORDER_VAL ('0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .din_valid  (din_valid),
    .din        (din),
    .vsync      (vsync),
    .dout       (dout),
    .dout_valid (dout_valid),
    .vsync_out  (vsync_out),
    .border     (border),
    .line_end   (line_end),
    .frame_end  (frame_end),
    .err_ovf    (err_ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] d;
    logic          b;
    logic          le;
    logic          fe;
    int            cyc;
  } exp_t;

  exp_t          q[$];
  int            total = 0;
  int            bad = 0;
  int            cyc = 0;
  int            le_cnt = 0;
  int            fe_cnt = 0;
  logic [DW-1:0] last_dout = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, req, $time);
    end
  endtask

  // Hand model: pixel index i sits at px=i%IW, ln=i/IW; din = i+1.
  task automatic push_pix(input int i);
    exp_t e;
    int   px, ln;
    px    = i % IW;
    ln    = i / IW;
    e.b   = (px == 0) || (px == 7) || (ln == 0) || (ln == 5);
    e.d   = e.b ? '0 : DW'(i + 1);
    e.le  = (px == 7);
    e.fe  = (i == 47);
    e.cyc = cyc + 1;
    q.push_back(e);
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic vs);
    din_valid = v;
    din       = d;
    vsync     = vs;
    @(posedge clk);
    #1;
    check("vsync_out", {31'b0, vsync_out}, {31'b0, vs});
  endtask

  task automatic run_pixels(input int n, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps && (i % 3 == 1)) drive(1'b0, 14'h3abc, 1'b0);
      if (gaps && (i % 5 == 0)) drive(1'b0, 14'h1234, 1'b0);
      push_pix(i);
      drive(1'b1, DW'(i + 1), 1'b0);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, 1'b0);
  endtask

  task automatic check_counts(input string name);
    check({name, "_line_end_cnt"}, le_cnt, 6);
    check({name, "_frame_end_cnt"}, fe_cnt, 1);
  endtask

  // Monitor: pop one expectation per dout_valid, otherwise check hold/idle outputs.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (dout_valid) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_dout: got dout=%0h with empty scoreboard", dout);
        end else begin
          e = q.pop_front();
          check("dout", {18'b0, dout}, {18'b0, e.d});
          check("flags", {29'b0, border, line_end, frame_end}, {29'b0, e.b, e.le, e.fe});
          check("latency_cycle", cyc, e.cyc);
          last_dout = e.d;
        end
        le_cnt += int'(line_end);
        fe_cnt += int'(frame_end);
      end else begin
        check("idle_flags", {29'b0, border, line_end, frame_end}, 32'd0);
        check("dout_hold", {18'b0, dout}, {18'b0, last_dout});
      end
    end
  end

  initial begin
    #2;
    check("reset_outputs", {dout, dout_valid, vsync_out, border, line_end, frame_end, err_ovf},
          '0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(2);

    // Continuous full frame.
    le_cnt = 0;
    fe_cnt = 0;
    run_pixels(48, 1'b0);
    idle(2);
    check_counts("cont");
    check("err_ovf_after_frame", {31'b0, err_ovf}, 32'd0);

    // Overflow after frame complete, then a 2-cycle vsync clears it.
    for (int i = 0; i < 3; i++) drive(1'b1, 14'h0fff, 1'b0);
    check("err_ovf_set", {31'b0, err_ovf}, 32'd1);
    drive(1'b0, '0, 1'b1);
    drive(1'b0, '0, 1'b1);
    check("err_ovf_cleared", {31'b0, err_ovf}, 32'd0);
    idle(2);

    // Same frame with gaps in din_valid.
    le_cnt = 0;
    fe_cnt = 0;
    run_pixels(48, 1'b1);
    idle(2);
    check_counts("gaps");
    drive(1'b0, '0, 1'b1);

    // Frame interrupted by vsync after 20 pixels; a coincident valid is dropped.
    run_pixels(20, 1'b0);
    drive(1'b1, 14'h2222, 1'b1);
    idle(1);
    le_cnt = 0;
    fe_cnt = 0;
    run_pixels(48, 1'b0);
    idle(2);
    check_counts("restart");
    drive(1'b0, '0, 1'b1);

    // Asynchronous reset mid-line (last output is interior pixel 12, dout=13).
    run_pixels(13, 1'b0);
    check("dout_before_reset", {18'b0, dout}, 32'd13);
    rst_n = 1'b0;
    q.delete();
    last_dout = '0;
    #1;
    check("async_reset_outputs",
          {dout, dout_valid, vsync_out, border, line_end, frame_end, err_ovf}, '0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(1);
    le_cnt = 0;
    fe_cnt = 0;
    run_pixels(48, 1'b0);
    idle(3);
    check_counts("after_reset");
    check("scoreboard_drained", q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
